// File: rtl/mem_access_ctrl_if.sv
// Execute-stage request, memory bus and load-return signals of the memory access controller.
// The slave modport is the controller's view; the master modport is the surrounding pipeline/bus.
interface mem_access_ctrl_if #(
  parameter int XLEN = 32
);
  logic            i_valid;
  logic            i_isLoad;
  logic            i_isStore;
  logic [2:0]      i_funct3;
  logic [XLEN-1:0] i_addr;
  logic [XLEN-1:0] i_storeData;
  logic            o_stall;
  logic            o_busReq;
  logic            o_busWe;
  logic [XLEN-1:0] o_busAddr;
  logic [3:0]      o_busByteEn;
  logic [XLEN-1:0] o_busWdata;
  logic            i_busAck;
  logic [XLEN-1:0] i_busRdata;
  logic            o_loadValid;
  logic [XLEN-1:0] o_loadData;
  logic [2:0]      o_loadFunct3;
  logic            o_fault;
  logic            o_busErr;

  modport slave (
    input  i_valid, i_isLoad, i_isStore, i_funct3, i_addr, i_storeData, i_busAck, i_busRdata,
    output o_stall, o_busReq, o_busWe, o_busAddr, o_busByteEn, o_busWdata,
           o_loadValid, o_loadData, o_loadFunct3, o_fault, o_busErr
  );

  modport master (
    output i_valid, i_isLoad, i_isStore, i_funct3, i_addr, i_storeData, i_busAck, i_busRdata,
    input  o_stall, o_busReq, o_busWe, o_busAddr, o_busByteEn, o_busWdata,
           o_loadValid, o_loadData, o_loadFunct3, o_fault, o_busErr
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// RV32 load/store unit front end: alignment checking, one word-aligned bus transaction per op,
// bus-wait timeout, and lane-0-aligned raw load return for the downstream extension stage.
module mem_access_ctrl #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input logic              i_clk,
  input logic              i_rst,
  mem_access_ctrl_if.slave bus
);
  typedef enum logic {IDLE, BUS} state_e;

  localparam int              CNT_W    = 10;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [3:0]      be_q, be_d;
  logic [1:0]      off_q, off_d;
  logic [2:0]      f3_q, f3_d;
  logic            is_load_q, is_load_d;
  logic            lvalid_q, lvalid_d;
  logic [XLEN-1:0] ldata_q, ldata_d;
  logic [2:0]      lf3_q, lf3_d;
  logic            fault_q, fault_d;
  logic            err_q, err_d;
  logic            accept;
  logic            misfit;

  function automatic logic [3:0] byte_en(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      2'd0:    byte_en = 4'b0001 << off;
      2'd1:    byte_en = 4'b0011 << {off[1], 1'b0};
      default: byte_en = 4'b1111;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] store_lanes(input logic [1:0] sz, input logic [XLEN-1:0] d);
    case (sz)
      2'd0:    store_lanes = {4{d[7:0]}};
      2'd1:    store_lanes = {2{d[15:0]}};
      default: store_lanes = d;
    endcase
  endfunction

  // Unsigned widths (4/5) are only meaningful for loads.
  always_comb begin
    case (bus.i_funct3)
      3'd0:    misfit = 1'b0;
      3'd1:    misfit = bus.i_addr[0];
      3'd2:    misfit = |bus.i_addr[1:0];
      3'd4:    misfit = bus.i_isStore;
      3'd5:    misfit = bus.i_isStore | bus.i_addr[0];
      default: misfit = 1'b1;
    endcase
  end

  assign accept = !i_rst && (state_q == IDLE) && bus.i_valid && (bus.i_isLoad ^ bus.i_isStore);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    off_d     = off_q;
    f3_d      = f3_q;
    is_load_d = is_load_q;
    ldata_d   = ldata_q;
    lf3_d     = lf3_q;
    lvalid_d  = 1'b0;
    fault_d   = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (misfit) begin
            fault_d = 1'b1;
          end else begin
            state_d   = BUS;
            cnt_d     = '0;
            req_d     = 1'b1;
            we_d      = bus.i_isStore;
            addr_d    = {bus.i_addr[XLEN-1:2], 2'b00};
            be_d      = byte_en(bus.i_funct3[1:0], bus.i_addr[1:0]);
            wdata_d   = bus.i_isStore ? store_lanes(bus.i_funct3[1:0], bus.i_storeData) : '0;
            off_d     = bus.i_addr[1:0];
            f3_d      = bus.i_funct3;
            is_load_d = bus.i_isLoad;
          end
        end
      end
      BUS: begin
        // An ack on the final allowed wait cycle still completes normally.
        if (bus.i_busAck) begin
          state_d = IDLE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          if (is_load_q) begin
            lvalid_d = 1'b1;
            ldata_d  = bus.i_busRdata >> {off_q, 3'b000};
            lf3_d    = f3_q;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      off_q     <= '0;
      f3_q      <= '0;
      is_load_q <= 1'b0;
      lvalid_q  <= 1'b0;
      ldata_q   <= '0;
      lf3_q     <= '0;
      fault_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      off_q     <= off_d;
      f3_q      <= f3_d;
      is_load_q <= is_load_d;
      lvalid_q  <= lvalid_d;
      ldata_q   <= ldata_d;
      lf3_q     <= lf3_d;
      fault_q   <= fault_d;
      err_q     <= err_d;
    end
  end

  assign bus.o_stall      = !i_rst && (accept || (state_q == BUS));
  assign bus.o_busReq     = req_q;
  assign bus.o_busWe      = we_q;
  assign bus.o_busAddr    = addr_q;
  assign bus.o_busByteEn  = be_q;
  assign bus.o_busWdata   = wdata_q;
  assign bus.o_loadValid  = lvalid_q;
  assign bus.o_loadData   = ldata_q;
  assign bus.o_loadFunct3 = lf3_q;
  assign bus.o_fault      = fault_q;
  assign bus.o_busErr     = err_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed and randomized checks of mem_access_ctrl against an arithmetic reference model.
module tb_mem_access_ctrl;
  localparam int TMO = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_access_ctrl_if #(.XLEN(32)) bif ();
  mem_access_ctrl #(.XLEN(32), .TIMEOUT(TMO)) dut (.i_clk(clk), .i_rst(rst), .bus(bif));

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_ldata = '0;
  logic [2:0]  exp_lf3 = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bif.i_valid   = 1'b0;
    bif.i_isLoad  = 1'b0;
    bif.i_isStore = 1'b0;
    bif.i_addr    = $urandom;
  endtask

  // Reference: access size in bytes, legality, lane mask and replicated store data.
  function automatic void model(input bit ld, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] d, output bit flt, output logic [3:0] be,
                                output logic [31:0] wd);
    int size;
    bit legal;
    int mask;
    size  = (f3 == 0 || f3 == 4) ? 1 : (f3 == 1 || f3 == 5) ? 2 : 4;
    legal = (f3 <= 2) || (ld && (f3 == 4 || f3 == 5));
    flt   = !legal || ((a % size) != 0);
    mask  = ((1 << size) - 1) << (a % 4);
    be    = mask[3:0];
    if (ld)             wd = 32'h0;
    else if (size == 1) wd = (d & 32'hFF) * 32'h01010101;
    else if (size == 2) wd = (d & 32'hFFFF) * 32'h00010001;
    else                wd = d;
  endfunction

  task automatic run_op(input bit ld, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, input int ack_at, input logic [31:0] rd);
    bit flt;
    bit acked;
    logic [3:0] be;
    logic [31:0] wd;
    model(ld, f3, a, d, flt, be, wd);
    bif.i_valid = 1'b1; bif.i_isLoad = ld; bif.i_isStore = !ld;
    bif.i_funct3 = f3; bif.i_addr = a; bif.i_storeData = d;
    @(negedge clk); chk("stall_accept", bif.o_stall, 1);
    tick(); idle_in();
    if (flt) begin
      chk("fault_pulse", bif.o_fault, 1);
      chk("fault_noreq", bif.o_busReq, 0);
      @(negedge clk); chk("fault_stall", bif.o_stall, 0);
      tick();
      chk("fault_clear", bif.o_fault, 0);
      chk("fault_noreq2", bif.o_busReq, 0);
      chk("fault_ldata_hold", bif.o_loadData, exp_ldata);
      return;
    end
    chk("no_fault", bif.o_fault, 0);
    acked = 1'b0;
    for (int k = 1; k <= TMO; k++) begin
      chk("bus_req", bif.o_busReq, 1);
      chk("bus_we", bif.o_busWe, !ld);
      chk("bus_addr", bif.o_busAddr, {a[31:2], 2'b00});
      chk("bus_be", bif.o_busByteEn, be);
      chk("bus_wdata", bif.o_busWdata, wd);
      @(negedge clk); chk("bus_stall", bif.o_stall, 1);
      if (k == ack_at) begin bif.i_busAck = 1'b1; bif.i_busRdata = rd; end
      tick();
      bif.i_busAck = 1'b0; bif.i_busRdata = $urandom;
      if (k == ack_at) begin acked = 1'b1; break; end
    end
    if (acked && ld) begin exp_ldata = rd >> (8 * (a % 4)); exp_lf3 = f3; end
    chk("req_drop", bif.o_busReq, 0);
    chk("bus_err", bif.o_busErr, !acked);
    chk("load_valid", bif.o_loadValid, acked && ld);
    chk("load_data", bif.o_loadData, exp_ldata);
    chk("load_f3", bif.o_loadFunct3, exp_lf3);
    @(negedge clk); chk("done_stall", bif.o_stall, 0);
    tick();
    chk("lv_clear", bif.o_loadValid, 0);
    chk("err_clear", bif.o_busErr, 0);
  endtask

  initial begin
    logic [31:0] ra;
    rst = 1'b1;
    bif.i_valid = 1'b1; bif.i_isLoad = 1'b1; bif.i_isStore = 1'b0;
    bif.i_funct3 = 3'd2; bif.i_addr = '0; bif.i_storeData = '0;
    bif.i_busAck = 1'b0; bif.i_busRdata = '0;
    tick(); tick();
    @(negedge clk); chk("rst_stall", bif.o_stall, 0);
    chk("rst_req", bif.o_busReq, 0);       chk("rst_we", bif.o_busWe, 0);
    chk("rst_addr", bif.o_busAddr, 0);     chk("rst_be", bif.o_busByteEn, 0);
    chk("rst_wdata", bif.o_busWdata, 0);   chk("rst_lv", bif.o_loadValid, 0);
    chk("rst_ldata", bif.o_loadData, 0);   chk("rst_lf3", bif.o_loadFunct3, 0);
    chk("rst_fault", bif.o_fault, 0);      chk("rst_err", bif.o_busErr, 0);
    tick(); rst = 1'b0; idle_in();
    tick();

    // Ack while idle is ignored
    bif.i_busAck = 1'b1; bif.i_busRdata = 32'hCAFEF00D;
    tick(); bif.i_busAck = 1'b0;
    chk("idle_ack_lv", bif.o_loadValid, 0);
    chk("idle_ack_req", bif.o_busReq, 0);

    run_op(1'b0, 3'd0, 32'h0000_1003, 32'hAABBCC11, 3, 32'h0);
    run_op(1'b1, 3'd5, 32'h0000_2002, 32'h0, 1, 32'h87654321);
    run_op(1'b1, 3'd2, 32'h0000_3001, 32'h0, 1, 32'h0);
    run_op(1'b1, 3'd2, 32'h0000_4000, 32'h0, TMO + 1, 32'h0);
    run_op(1'b1, 3'd2, 32'h0000_4004, 32'h0, TMO, 32'hDEADBEEF);
    run_op(1'b0, 3'd4, 32'h0000_5000, 32'h1234, 1, 32'h0);
    run_op(1'b1, 3'd0, 32'h0000_5001, 32'h0, 2, 32'h11223344);

    // Reset in the middle of a bus cycle, followed by a late ack
    bif.i_valid = 1'b1; bif.i_isLoad = 1'b1; bif.i_isStore = 1'b0;
    bif.i_funct3 = 3'd2; bif.i_addr = 32'h0000_5000;
    tick(); idle_in();
    chk("rb_req", bif.o_busReq, 1);
    rst = 1'b1;
    @(negedge clk); chk("rb_stall", bif.o_stall, 0);
    tick(); rst = 1'b0; bif.i_busAck = 1'b1; bif.i_busRdata = 32'h55AA55AA;
    exp_ldata = '0; exp_lf3 = '0;
    chk("rb_req0", bif.o_busReq, 0);     chk("rb_addr", bif.o_busAddr, 0);
    chk("rb_be", bif.o_busByteEn, 0);    chk("rb_ldata", bif.o_loadData, 0);
    chk("rb_lf3", bif.o_loadFunct3, 0);  chk("rb_we", bif.o_busWe, 0);
    tick(); bif.i_busAck = 1'b0;
    chk("rb_lv", bif.o_loadValid, 0);
    chk("rb_req1", bif.o_busReq, 0);
    chk("rb_err", bif.o_busErr, 0);

    // Back-to-back: SW, then LB presented while the SW is on the bus
    bif.i_valid = 1'b1; bif.i_isLoad = 1'b0; bif.i_isStore = 1'b1;
    bif.i_funct3 = 3'd2; bif.i_addr = 32'h0000_6008; bif.i_storeData = 32'h12345678;
    @(negedge clk); chk("b2b_stall0", bif.o_stall, 1);
    tick();
    bif.i_isLoad = 1'b1; bif.i_isStore = 1'b0; bif.i_funct3 = 3'd0; bif.i_addr = 32'h0000_7003;
    for (int k = 0; k < 2; k++) begin
      chk("b2b_sw_req", bif.o_busReq, 1);
      chk("b2b_sw_addr", bif.o_busAddr, 32'h0000_6008);
      chk("b2b_sw_be", bif.o_busByteEn, 4'hF);
      chk("b2b_sw_wd", bif.o_busWdata, 32'h12345678);
      chk("b2b_sw_we", bif.o_busWe, 1);
      @(negedge clk);
      if (k == 1) bif.i_busAck = 1'b1;
      tick();
    end
    bif.i_busAck = 1'b0;
    chk("b2b_sw_drop", bif.o_busReq, 0);
    chk("b2b_sw_lv", bif.o_loadValid, 0);
    @(negedge clk); chk("b2b_lb_accept", bif.o_stall, 1);
    tick(); idle_in();
    chk("b2b_lb_req", bif.o_busReq, 1);
    chk("b2b_lb_addr", bif.o_busAddr, 32'h0000_7000);
    chk("b2b_lb_be", bif.o_busByteEn, 4'b1000);
    chk("b2b_lb_we", bif.o_busWe, 0);
    @(negedge clk); bif.i_busAck = 1'b1; bif.i_busRdata = 32'hA1B2C3D4;
    tick(); bif.i_busAck = 1'b0;
    exp_ldata = 32'h0000_00A1; exp_lf3 = 3'd0;
    chk("b2b_lb_lv", bif.o_loadValid, 1);
    chk("b2b_lb_data", bif.o_loadData, exp_ldata);
    tick();
    chk("b2b_lb_lv0", bif.o_loadValid, 0);

    // Randomized operations
    for (int n = 0; n < 40; n++) begin
      ra = $urandom;
      if ($urandom_range(0, 1) == 1) ra[1:0] = 2'b00;
      run_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ra, $urandom,
             int'($urandom_range(1, TMO + 1)), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter: XLEN, 32, data/address width; only 32 is supported.
REQ-002 Parameter: TIMEOUT, 255, maximum bus-wait cycles before error abort (1..1023).
REQ-003 i_clk  in  1  single clock; all state updates on rising edge.
REQ-004 i_rst  in  1  reset, synchronous and active-high.
REQ-005 i_valid  in  1  memory-op request from execute stage.
REQ-006 i_isLoad / i_isStore  in  1 each  op type; both high or both low with i_valid treated as no request.
REQ-007 i_funct3  in  3  RV32 load/store width code (0 B, 1 H, 2 W, 4 BU, 5 HU).
REQ-008 i_addr  in  XLEN  byte address; i_storeData  in  XLEN  store source.
REQ-009 o_stall  out  1  hold upstream pipeline.
REQ-010 o_busReq  out  1; o_busWe  out  1; o_busAddr  out  XLEN (bits[1:0]=0); o_busByteEn  out  4; o_busWdata  out  XLEN.
REQ-011 i_busAck  in  1  one-cycle completion strobe; i_busRdata  in  XLEN  valid when i_busAck.
REQ-012 o_loadValid  out  1; o_loadData  out  XLEN lane-0-aligned raw load data; o_loadFunct3  out  3; these feed the downstream width/sign-extension stage.
REQ-013 o_fault  out  1  misaligned/illegal-width pulse; o_busErr  out  1  timeout pulse.

Function
REQ-014 FSM states: IDLE, BUS. Accept = IDLE & i_valid & exactly one of i_isLoad/i_isStore.
REQ-015 Fault = accepted op with funct3 in {3,6,7}, or H/HU with addr[0]=1, or W with addr[1:0]!=0; loads only may use 4/5 (store with funct3 4/5 is a fault).
REQ-016 Faulting accept: no bus cycle; o_fault=1 for exactly the next cycle; remain IDLE.
REQ-017 Good accept: capture op; next cycle enter BUS with o_busReq=1; o_busAddr={addr[31:2],2'b00}; o_busWe=isStore.
REQ-018 Byte enables: B/BU 4'b0001<<addr[1:0]; H/HU 4'b0011<<{addr[1],1'b0}; W 4'b1111; same for loads and stores.
REQ-019 Write data: B {4{data[7:0]}}; H {2{data[15:0]}}; W data; o_busWdata=0 for loads.
REQ-020 Bus outputs held constant throughout BUS until the ack cycle.
REQ-021 i_busAck in BUS: next cycle o_busReq=0, state IDLE; for loads o_loadValid=1 for that one cycle, o_loadData=i_busRdata>>(8*addr[1:0]) zero-filled, o_loadFunct3=captured funct3.
REQ-022 o_stall = Accept (combinational) OR state==BUS; low in the cycle o_loadValid is high.
REQ-023 Wait counter cleared on BUS entry, increments each BUS cycle without ack; when count reaches TIMEOUT without ack: o_busErr=1 next cycle, o_busReq=0, IDLE, no o_loadValid.
REQ-024 Ack in the same cycle count reaches TIMEOUT: ack wins, no o_busErr.
REQ-025 i_busAck while IDLE ignored; i_valid while BUS ignored.
REQ-026 o_loadData/o_loadFunct3 hold last value when o_loadValid=0.

Reset
REQ-027 i_rst at any edge: state IDLE, counter 0; o_busReq, o_busWe, o_loadValid, o_fault, o_busErr = 0; o_busAddr, o_busByteEn, o_busWdata, o_loadData, o_loadFunct3 = 0.
REQ-028 Reset during BUS aborts the transaction; an ack arriving after reset produces no o_loadValid.
REQ-029 i_rst overrides Accept; o_stall=0 while i_rst high.

Verification
REQ-030 SB addr 0x1003 data 0xAABBCC11 -> o_busAddr 0x1000, ByteEn 1000, Wdata 0x11111111, We=1; ack after 3 cycles -> o_busReq drops next cycle, no o_loadValid.
REQ-031 LHU addr 0x2002, rdata 0x8765_4321 ack -> o_loadValid one cycle, o_loadData 0x00008765, o_loadFunct3 5, ByteEn 1100.
REQ-032 LW addr 0x3001 -> o_fault pulse one cycle, o_busReq never asserts, o_stall high for accept cycle only.
REQ-033 TIMEOUT=4, LW with no ack -> o_busErr pulse after 4 BUS cycles, o_busReq 0, IDLE; variant with ack on 4th cycle -> o_loadValid, no o_busErr.
REQ-034 i_rst during BUS then ack next cycle -> all outputs reset values, no o_loadValid.
REQ-035 Back-to-back: SW then LB with i_valid held -> second op accepted only in first IDLE cycle after completion; bus outputs stable across each BUS period.
